// File: rtl/jtag_pkg.sv
// jtag_pkg: IEEE 1149.1 TAP state encodings and sequencer FSM states, shared with the
// per-port boot-config engines. Also supplies the default `NUM_DEV port count.
`ifndef NUM_DEV
`define NUM_DEV 3
`endif

package jtag_pkg;

    localparam logic [3:0] TAP_TLR   = 4'hF;
    localparam logic [3:0] TAP_RTI   = 4'hC;
    localparam logic [3:0] TAP_SELDR = 4'h7;
    localparam logic [3:0] TAP_CAPDR = 4'h6;
    localparam logic [3:0] TAP_SHDR  = 4'h2;
    localparam logic [3:0] TAP_EX1DR = 4'h1;
    localparam logic [3:0] TAP_PAUDR = 4'h3;
    localparam logic [3:0] TAP_EX2DR = 4'h0;
    localparam logic [3:0] TAP_UPDDR = 4'h5;
    localparam logic [3:0] TAP_SELIR = 4'h4;
    localparam logic [3:0] TAP_CAPIR = 4'hE;
    localparam logic [3:0] TAP_SHIR  = 4'hA;
    localparam logic [3:0] TAP_EX1IR = 4'h9;
    localparam logic [3:0] TAP_PAUIR = 4'hB;
    localparam logic [3:0] TAP_EX2IR = 4'h8;
    localparam logic [3:0] TAP_UPDIR = 4'hD;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_WAIT = 2'd2,
        SEQ_FIN  = 2'd3
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jtag_tap_sequencer_if.sv
// Control/status bundle between the boot controller, the config chain and the TAP sequencer.
`ifndef NUM_DEV
`define NUM_DEV 3
`endif

interface jtag_tap_sequencer_if;

    logic                 start;
    logic                 chain_done;
    logic [`NUM_DEV:0]    tck;
    logic [3:0]           tap_state;
    logic                 busy;
    logic                 boot_done;
    logic                 err;

    modport master (
        output start, chain_done,
        input  tck, tap_state, busy, boot_done, err
    );

    modport slave (
        input  start, chain_done,
        output tck, tap_state, busy, boot_done, err
    );

endinterface

// File: rtl/jtag_tck_div.sv
// jtag_tck_div: enable-gated divider producing TCK (half-period TCK_DIV clk) plus 1-clk
// strobes that are high in the cycle whose closing clk edge makes tck rise or fall.
module jtag_tck_div #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck_q,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int               CNT_W    = $clog2(TCK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             wrap;

    assign wrap     = en && (cnt_q == CNT_LAST);
    assign rise_stb = wrap && !tck_q;
    assign fall_stb = wrap &&  tck_q;

    // Dropping en parks tck low and rearms the count, so the first rise after
    // enabling is always exactly TCK_DIV clk away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (wrap) begin
            cnt_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: drives TCK and a common TAP state through the boot scan sequence.
// Optional JTAG_IR_SCAN_EN inserts an IR scan between Test-Logic-Reset and the DR scan.
module jtag_tap_sequencer
    import jtag_pkg::*;
#(
    parameter int TCK_DIV     = 4,
    parameter int TLR_TCKS    = 5,
    parameter int DR_LEN      = 32,
    parameter int IR_LEN      = 6,
    parameter int TIMEOUT_TCK = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jtag_tap_sequencer_if.slave  bus
);

    localparam int SH_MAX = max_int(DR_LEN, IR_LEN);
    localparam int TLR_W  = $clog2(TLR_TCKS + 1);
    localparam int SH_W   = $clog2(SH_MAX + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_TCK + 1);

    localparam logic [TLR_W-1:0] TLR_LAST = TLR_W'(TLR_TCKS);
    localparam logic [SH_W-1:0]  DR_LAST  = SH_W'(DR_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TCK - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_TCK);
`ifdef JTAG_IR_SCAN_EN
    localparam logic [SH_W-1:0]  IR_LAST  = SH_W'(IR_LEN);
`endif

    seq_state_e       state_q, state_d;
    logic [3:0]       tap_q, tap_d;
    logic [TLR_W-1:0] tlr_cnt_q, tlr_cnt_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             boot_done_q, boot_done_d;
    logic             err_q, err_d;
`ifdef JTAG_IR_SCAN_EN
    logic             ir_done_q, ir_done_d;
`endif

    logic busy;
    logic tck_q;
    logic fall_stb;
    logic rise_stb;

    assign busy = (state_q == SEQ_RUN) || (state_q == SEQ_WAIT);

    jtag_tck_div #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (busy),
        .tck_q    (tck_q),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEQ_IDLE;
            tap_q       <= TAP_TLR;
            tlr_cnt_q   <= '0;
            sh_cnt_q    <= '0;
            tmo_cnt_q   <= '0;
            boot_done_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef JTAG_IR_SCAN_EN
            ir_done_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            tlr_cnt_q   <= tlr_cnt_d;
            sh_cnt_q    <= sh_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            boot_done_q <= boot_done_d;
            err_q       <= err_d;
`ifdef JTAG_IR_SCAN_EN
            ir_done_q   <= ir_done_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path can infer a latch.
        state_d     = state_q;
        tap_d       = tap_q;
        tlr_cnt_d   = tlr_cnt_q;
        sh_cnt_d    = sh_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        boot_done_d = boot_done_q;
        err_d       = err_q;
`ifdef JTAG_IR_SCAN_EN
        ir_done_d   = ir_done_q;
`endif

        case (state_q)
            SEQ_IDLE, SEQ_FIN: begin
                // tap_state is left alone here; TLR is re-entered on the first falling edge.
                if (bus.start) begin
                    state_d     = SEQ_RUN;
                    tlr_cnt_d   = '0;
                    sh_cnt_d    = '0;
                    tmo_cnt_d   = '0;
                    boot_done_d = 1'b0;
                    err_d       = 1'b0;
`ifdef JTAG_IR_SCAN_EN
                    ir_done_d   = 1'b0;
`endif
                end
            end

            SEQ_RUN: begin
                if (fall_stb) begin
                    if (tlr_cnt_q != TLR_LAST) begin
                        tap_d     = TAP_TLR;
                        tlr_cnt_d = tlr_cnt_q + TLR_W'(1);
                    end else begin
                        case (tap_q)
                            TAP_TLR:   tap_d = TAP_RTI;
                            TAP_RTI:   tap_d = TAP_SELDR;
`ifdef JTAG_IR_SCAN_EN
                            TAP_SELDR: tap_d = ir_done_q ? TAP_CAPDR : TAP_SELIR;
                            TAP_SELIR: tap_d = TAP_CAPIR;
                            TAP_CAPIR: begin
                                tap_d    = TAP_SHIR;
                                sh_cnt_d = SH_W'(1);
                            end
                            TAP_SHIR: begin
                                if (sh_cnt_q == IR_LAST) begin
                                    tap_d    = TAP_EX1IR;
                                    sh_cnt_d = '0;
                                end else begin
                                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                                end
                            end
                            TAP_EX1IR: tap_d = TAP_UPDIR;
                            TAP_UPDIR: begin
                                tap_d     = TAP_SELDR;
                                ir_done_d = 1'b1;
                            end
`else
                            TAP_SELDR: tap_d = TAP_CAPDR;
`endif
                            TAP_CAPDR: begin
                                tap_d    = TAP_SHDR;
                                sh_cnt_d = SH_W'(1);
                            end
                            TAP_SHDR: begin
                                if (sh_cnt_q == DR_LAST) begin
                                    tap_d    = TAP_EX1DR;
                                    sh_cnt_d = '0;
                                end else begin
                                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                                end
                            end
                            TAP_EX1DR: tap_d = TAP_UPDDR;
                            TAP_UPDDR: begin
                                tap_d     = TAP_RTI;
                                tmo_cnt_d = '0;
                                state_d   = SEQ_WAIT;
                            end
                            // Any state outside the walk restarts it from Test-Logic-Reset.
                            default:   tap_d = TAP_TLR;
                        endcase
                    end
                end
            end

            SEQ_WAIT: begin
                if (fall_stb) begin
                    if (bus.chain_done) begin
                        state_d     = SEQ_FIN;
                        boot_done_d = 1'b1;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d   = SEQ_FIN;
                        err_d     = 1'b1;
                        tmo_cnt_d = TMO_SAT;
                    end else if (tmo_cnt_q != TMO_SAT) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
            end

            default: state_d = SEQ_IDLE;
        endcase
    end

    tap_stable_on_rise: assert property (
        @(posedge clk) disable iff (!rst_n) rise_stb |=> $stable(tap_q)
    );

    assign bus.tck       = {(`NUM_DEV + 1){tck_q}};
    assign bus.tap_state = tap_q;
    assign bus.busy      = busy;
    assign bus.boot_done = boot_done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: randomized scenarios; a reference model queues the expected
// per-TCK-fall TAP state and flags, and a monitor compares them on every observed fall.
`ifndef NUM_DEV
`define NUM_DEV 3
`endif

module tb_jtag_tap_sequencer;

    localparam int TCK_DIV  = 4;
    localparam int TLR_TCKS = 5;
    localparam int DR_LEN   = 32;
    localparam int IR_LEN   = 6;
    localparam int TMO      = 16;
`ifdef JTAG_IR_SCAN_EN
    localparam int IR_STEPS = IR_LEN + 5;
`else
    localparam int IR_STEPS = 0;
`endif
    localparam int N_WALK   = TLR_TCKS + 2 + IR_STEPS + 1 + DR_LEN + 3;
    localparam int BUDGET   = (N_WALK + TMO + 4) * 2 * TCK_DIV;

    typedef struct packed {
        logic [3:0] tap;
        logic       busy;
        logic       boot_done;
        logic       err;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t sb[$];

    jtag_tap_sequencer_if bus ();

    jtag_tap_sequencer #(
        .TCK_DIV     (TCK_DIV),
        .TLR_TCKS    (TLR_TCKS),
        .DR_LEN      (DR_LEN),
        .IR_LEN      (IR_LEN),
        .TIMEOUT_TCK (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the TAP walk as a list of states, then the wait in Run-Test/Idle.
    // k_done < 0: chain_done never rises; k_done = 0: high before start; otherwise it
    // is raised right after TCK fall number k_done and first seen on the next fall.
    task automatic model_push(input int k_done, output rec_t last);
        logic [3:0] w[$];
        int n, j, wd;
        repeat (TLR_TCKS) w.push_back(4'hF);
        w.push_back(4'hC);
        w.push_back(4'h7);
`ifdef JTAG_IR_SCAN_EN
        w.push_back(4'h4);
        w.push_back(4'hE);
        repeat (IR_LEN) w.push_back(4'hA);
        w.push_back(4'h9);
        w.push_back(4'hD);
        w.push_back(4'h7);
`endif
        w.push_back(4'h6);
        repeat (DR_LEN) w.push_back(4'h2);
        w.push_back(4'h1);
        w.push_back(4'h5);
        w.push_back(4'hC);
        foreach (w[i]) sb.push_back('{tap: w[i], busy: 1'b1, boot_done: 1'b0, err: 1'b0});
        n  = w.size();
        j  = ((k_done > n) ? k_done : n) + 1;
        wd = j - n;
        if (k_done >= 0 && wd <= TMO) begin
            repeat (wd - 1) sb.push_back('{tap: 4'hC, busy: 1'b1, boot_done: 1'b0, err: 1'b0});
            last = '{tap: 4'hC, busy: 1'b0, boot_done: 1'b1, err: 1'b0};
        end else begin
            repeat (TMO - 1) sb.push_back('{tap: 4'hC, busy: 1'b1, boot_done: 1'b0, err: 1'b0});
            last = '{tap: 4'hC, busy: 1'b0, boot_done: 1'b0, err: 1'b1};
        end
        sb.push_back(last);
    endtask

    // Monitor: samples on the falling clk edge, pops one expectation per TCK fall.
    initial begin
        logic       prev_tck = 1'b0;
        logic [3:0] prev_tap = 4'hF;
        logic       fell;
        int         mon_falls = 0;
        rec_t       e, a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_tck = 1'b0;
                prev_tap = 4'hF;
            end else begin
                fell = prev_tck && !bus.tck[0];
                if (bus.tap_state !== prev_tap)
                    check("tap_change_on_tck_fall", 32'(fell), 32'd1);
                if (fell) begin
                    mon_falls++;
                    check($sformatf("tck_fanout_low_fall%0d", mon_falls), 32'(bus.tck), 32'd0);
                    if (sb.size() == 0) begin
                        check($sformatf("unexpected_fall%0d", mon_falls), 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        a = '{tap: bus.tap_state, busy: bus.busy, boot_done: bus.boot_done, err: bus.err};
                        check($sformatf("fall%0d_tap_busy_done_err", mon_falls), 32'(a), 32'(e));
                    end
                end
                prev_tck = bus.tck[0];
                prev_tap = bus.tap_state;
            end
        end
    end

    // One start-to-finish sequence. k_start: TCK fall after which a stray start is pulsed.
    // k_rst: TCK fall after which rst_n is asserted mid-sequence (-1 for none).
    task automatic run_scenario(input int k_done, input int k_start, input int k_rst);
        rec_t last;
        int   cyc, falls, rises, r1, r2, f1;
        logic prev, t, stop, aborted;
        model_push(k_done, last);
        bus.chain_done = (k_done == 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("flags_clear_on_start", 32'({bus.boot_done, bus.err}), 32'd0);
        cyc = 0; falls = 0; rises = 0; r1 = -1; r2 = -1; f1 = -1;
        prev = 1'b0; stop = 1'b0; aborted = 1'b0;
        while (!stop) begin
            bus.start = 1'b0;
            t = bus.tck[0];
            if (t && !prev) begin
                rises++;
                if (rises == 1) r1 = cyc;
                if (rises == 2) r2 = cyc;
            end
            if (!t && prev) begin
                falls++;
                if (falls == 1) f1 = cyc;
                if (falls == k_done) bus.chain_done = 1'b1;
                if (falls == k_start) bus.start = 1'b1;
                if (falls == k_rst) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("async_rst_tck", 32'(bus.tck), 32'd0);
                    check("async_rst_tap", 32'(bus.tap_state), 32'hF);
                    check("async_rst_busy_flags", 32'({bus.busy, bus.boot_done, bus.err}), 32'd0);
                    stop = 1'b1;
                    aborted = 1'b1;
                end
            end
            prev = t;
            if (!stop && !bus.busy) stop = 1'b1;
            if (!stop && cyc >= BUDGET) begin
                check("sequence_end_within_budget", 32'(cyc), 32'(BUDGET - 1));
                stop = 1'b1;
            end
            if (!stop) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        check("first_tck_rise_clk", 32'(r1), 32'(TCK_DIV));
        check("first_tck_fall_clk", 32'(f1), 32'(2 * TCK_DIV));
        check("second_tck_rise_clk", 32'(r2), 32'(3 * TCK_DIV));
        if (aborted) begin
            @(negedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
        end else begin
            repeat (3) @(negedge clk);
            check("scoreboard_drained", 32'(sb.size()), 32'd0);
            check("fin_tck_parked", 32'(bus.tck), 32'd0);
            check("fin_tap_rti", 32'(bus.tap_state), 32'hC);
            check("fin_busy_done_err", 32'({bus.busy, bus.boot_done, bus.err}),
                  32'({1'b0, last.boot_done, last.err}));
        end
        bus.chain_done = 1'b0;
    endtask

    initial begin
        int kd, ks;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.chain_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tck", 32'(bus.tck), 32'd0);
        check("reset_tap", 32'(bus.tap_state), 32'hF);
        check("reset_busy_done_err", 32'({bus.busy, bus.boot_done, bus.err}), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tck_low", 32'(bus.tck), 32'd0);

        run_scenario(0, -1, -1);
        run_scenario(-1, -1, -1);
        run_scenario(-1, 20, -1);
        run_scenario(0, -1, TLR_TCKS + 3 + IR_STEPS + 11);
        run_scenario(0, -1, -1);

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
                0:       kd = -1;
                1:       kd = 0;
                2:       kd = int'($urandom_range(1, N_WALK));
                default: kd = N_WALK + int'($urandom_range(0, TMO + 2));
            endcase
            ks = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N_WALK - 1)) : -1;
            run_scenario(kd, ks, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
